// File: rtl/circuito_exp4_desafio_pkg.sv
// ---------------------------------------------------------------------------
// circuito_exp4_desafio_pkg
// Shared definitions for the memory-game core:
//   - state_t   : FSM state encoding (the code is also shown on db_estado)
//   - rom_word  : contents of the fixed 16x4 sequence ROM
// ---------------------------------------------------------------------------
package circuito_exp4_desafio_pkg;

  typedef enum logic [3:0] {
    ST_INICIAL     = 4'h0,
    ST_PREPARACAO  = 4'h1,
    ST_REGISTRA    = 4'h4,
    ST_COMPARACAO  = 4'h5,
    ST_PROXIMO     = 4'h6,
    ST_FIM_ACERTOU = 4'hA,
    ST_FIM_ERROU   = 4'hE
  } state_t;

  localparam logic [3:0] LAST_ADDR = 4'hF;

  // Expected sequence the player must reproduce, one word per address.
  function automatic logic [3:0] rom_word(input logic [3:0] addr);
    logic [3:0] word;
    case (addr)
      4'h0: word = 4'h1;
      4'h1: word = 4'h2;
      4'h2: word = 4'h4;
      4'h3: word = 4'h8;
      4'h4: word = 4'h4;
      4'h5: word = 4'h2;
      4'h6: word = 4'h1;
      4'h7: word = 4'h1;
      4'h8: word = 4'h2;
      4'h9: word = 4'h2;
      4'hA: word = 4'h4;
      4'hB: word = 4'h4;
      4'hC: word = 4'h8;
      4'hD: word = 4'h8;
      4'hE: word = 4'h1;
      default: word = 4'h4;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/hexa7seg.sv
// ---------------------------------------------------------------------------
// hexa7seg
// Hex digit to 7-segment decoder, active-low, bit order gfedcba.
//   hexa    in  4  value to display
//   display out 7  segment pattern (0 = segment lit)
// ---------------------------------------------------------------------------
module hexa7seg (
  input  logic [3:0] hexa,
  output logic [6:0] display
);

  always_comb begin
    display = 7'b1111111;
    case (hexa)
      4'h0: display = 7'b1000000;
      4'h1: display = 7'b1111001;
      4'h2: display = 7'b0100100;
      4'h3: display = 7'b0110000;
      4'h4: display = 7'b0011001;
      4'h5: display = 7'b0010010;
      4'h6: display = 7'b0000010;
      4'h7: display = 7'b1111000;
      4'h8: display = 7'b0000000;
      4'h9: display = 7'b0010000;
      4'hA: display = 7'b0001000;
      4'hB: display = 7'b0000011;
      4'hC: display = 7'b1000110;
      4'hD: display = 7'b0100001;
      4'hE: display = 7'b0000110;
      default: display = 7'b0001110;
    endcase
  end

endmodule

// File: rtl/circuito_exp4_desafio_core.sv
// ---------------------------------------------------------------------------
// circuito_exp4_desafio_core
// Memory game: the player enters 16 values on chaves, each compared against a
// fixed ROM sequence. Any mismatch ends the game in FIM_ERROU, sixteen
// matches end it in FIM_ACERTOU.
//   clock        in   system clock, rising edge
//   reset        in   asynchronous, active-low
//   iniciar      in   start / restart request
//   chaves       in 4 player entry
//   pronto       out  game over
//   acertou      out  game won
//   errou        out  game lost
//   db_igual     out  registered entry == ROM[counter]
//   db_iniciar   out  copy of iniciar
//   db_contagem  out 7 7-seg of address counter
//   db_memoria   out 7 7-seg of current ROM word
//   db_chaves    out 7 7-seg of registered entry
//   db_estado    out 7 7-seg of FSM state code
// ---------------------------------------------------------------------------
module circuito_exp4_desafio_core
  import circuito_exp4_desafio_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] chaves,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       db_igual,
  output logic       db_iniciar,
  output logic [6:0] db_contagem,
  output logic [6:0] db_memoria,
  output logic [6:0] db_chaves,
  output logic [6:0] db_estado
);

  state_t     state_q, state_d;
  logic [3:0] contagem_q, contagem_d;
  logic [3:0] registro_q, registro_d;
  logic       pronto_q, pronto_d;
  logic       acertou_q, acertou_d;
  logic       errou_q, errou_d;
  logic [3:0] memoria;

  assign memoria  = rom_word(contagem_q);
  assign db_igual = (registro_q == memoria);

  always_comb begin
    state_d    = state_q;
    contagem_d = contagem_q;
    registro_d = registro_q;

    case (state_q)
      ST_INICIAL: begin
        if (iniciar) state_d = ST_PREPARACAO;
      end
      ST_PREPARACAO: begin
        contagem_d = 4'h0;
        registro_d = 4'h0;
        state_d    = ST_REGISTRA;
      end
      ST_REGISTRA: begin
        registro_d = chaves;
        state_d    = ST_COMPARACAO;
      end
      ST_COMPARACAO: begin
        if (!db_igual)                     state_d = ST_FIM_ERROU;
        else if (contagem_q == LAST_ADDR)  state_d = ST_FIM_ACERTOU;
        else                               state_d = ST_PROXIMO;
      end
      ST_PROXIMO: begin
        // Address 15 never reaches this state, so the counter cannot wrap.
        contagem_d = contagem_q + 4'h1;
        state_d    = ST_REGISTRA;
      end
      ST_FIM_ACERTOU, ST_FIM_ERROU: begin
        if (iniciar) state_d = ST_PREPARACAO;
      end
      default: state_d = ST_INICIAL;
    endcase

    // Flags are registered from the next state so they line up with state_q.
    pronto_d  = (state_d == ST_FIM_ACERTOU) || (state_d == ST_FIM_ERROU);
    acertou_d = (state_d == ST_FIM_ACERTOU);
    errou_d   = (state_d == ST_FIM_ERROU);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_INICIAL;
      contagem_q <= 4'h0;
      registro_q <= 4'h0;
      pronto_q   <= 1'b0;
      acertou_q  <= 1'b0;
      errou_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      contagem_q <= contagem_d;
      registro_q <= registro_d;
      pronto_q   <= pronto_d;
      acertou_q  <= acertou_d;
      errou_q    <= errou_d;
    end
  end

  assign pronto     = pronto_q;
  assign acertou    = acertou_q;
  assign errou      = errou_q;
  assign db_iniciar = iniciar;

  // Four debug displays: counter, ROM word, entry register, state code.
  logic [3:0] hex_in  [4];
  logic [6:0] seg_out [4];

  assign hex_in[0] = contagem_q;
  assign hex_in[1] = memoria;
  assign hex_in[2] = registro_q;
  assign hex_in[3] = state_q;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_hex
      hexa7seg u_hexa7seg (
        .hexa    (hex_in[gi]),
        .display (seg_out[gi])
      );
    end
  endgenerate

  assign db_contagem = seg_out[0];
  assign db_memoria  = seg_out[1];
  assign db_chaves   = seg_out[2];
  assign db_estado   = seg_out[3];

endmodule

// File: tb/tb_circuito_exp4_desafio_core.sv
module tb_circuito_exp4_desafio_core;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic [3:0] chaves = 4'h0;
  logic       pronto, acertou, errou, db_igual, db_iniciar;
  logic [6:0] db_contagem, db_memoria, db_chaves, db_estado;

  int checks = 0;
  int passes = 0;

  circuito_exp4_desafio_core dut (
    .clock       (clock),
    .reset       (reset),
    .iniciar     (iniciar),
    .chaves      (chaves),
    .pronto      (pronto),
    .acertou     (acertou),
    .errou       (errou),
    .db_igual    (db_igual),
    .db_iniciar  (db_iniciar),
    .db_contagem (db_contagem),
    .db_memoria  (db_memoria),
    .db_chaves   (db_chaves),
    .db_estado   (db_estado)
  );

  always #5 clock = ~clock;

  // Expected sequence as listed for the game.
  int rom_m [16] = '{1, 2, 4, 8, 4, 2, 1, 1, 2, 2, 4, 4, 8, 8, 1, 4};

  function automatic logic [6:0] seg(input int v);
    logic [6:0] tab [16];
    tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return tab[v & 15];
  endfunction

  // Game model: index of first wrong entry, or 16 when all are right.
  function automatic int first_bad(input logic [3:0] e [16]);
    for (int i = 0; i < 16; i++)
      if (int'(e[i]) != rom_m[i]) return i;
    return 16;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    #2 reset = 1'b0;
    #3 reset = 1'b1;
    iniciar = 1'b0;
    tick();
  endtask

  // Plays one game from INICIAL or a FIM state: start pulse, PREPARACAO,
  // then each entry held for its REGISTRA/COMPARACAO/PROXIMO window.
  task automatic drive_game(input logic [3:0] e [16]);
    int last;
    last = first_bad(e);
    if (last > 15) last = 15;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
    for (int i = 0; i <= last; i++) begin
      chaves = e[i];
      tick();
      tick();
      if (i < last) tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    checks++; if (db_estado !== seg(0) || pronto !== 1'b0 || acertou !== 1'b0 || errou !== 1'b0)
      $display("FAIL reset_state estado=%b pronto=%b acertou=%b errou=%b", db_estado, pronto, acertou, errou);
    else passes++;
    checks++; if (db_contagem !== seg(0) || db_chaves !== seg(0) || db_memoria !== seg(1))
      $display("FAIL reset_displays cont=%b chaves=%b mem=%b", db_contagem, db_chaves, db_memoria);
    else passes++;
    reset = 1'b1;
    tick();
    tick();
    checks++; if (db_estado !== seg(0)) $display("FAIL idle_hold estado=%b exp=%b", db_estado, seg(0));
    else passes++;
    $display("reset: done");
  endtask

  task automatic test_start();
    iniciar = 1'b1;
    #1;
    checks++; if (db_iniciar !== 1'b1) $display("FAIL db_iniciar got=%b exp=1", db_iniciar);
    else passes++;
    tick();
    iniciar = 1'b0;
    checks++; if (db_estado !== seg(1)) $display("FAIL start_prep estado=%b exp=%b", db_estado, seg(1));
    else passes++;
    tick();
    checks++; if (db_estado !== seg(4) || db_contagem !== seg(0) || pronto !== 1'b0)
      $display("FAIL start_registra estado=%b cont=%b pronto=%b", db_estado, db_contagem, pronto);
    else passes++;
    // iniciar mid-game must not disturb the sequence
    iniciar = 1'b1;
    chaves = 4'h1;
    tick();
    checks++; if (db_estado !== seg(5) || db_igual !== 1'b1)
      $display("FAIL ignore_iniciar_cmp estado=%b igual=%b", db_estado, db_igual);
    else passes++;
    tick();
    checks++; if (db_estado !== seg(6)) $display("FAIL ignore_iniciar_prox estado=%b exp=%b", db_estado, seg(6));
    else passes++;
    tick();
    iniciar = 1'b0;
    checks++; if (db_estado !== seg(4) || db_contagem !== seg(1))
      $display("FAIL next_entry estado=%b cont=%b", db_estado, db_contagem);
    else passes++;
    $display("start: done");
    apply_reset();
  endtask

  task automatic check_end(input logic [3:0] e [16], input string name);
    int k;
    logic win;
    int last;
    k = first_bad(e);
    win = (k == 16);
    last = win ? 15 : k;
    checks++; if (pronto !== 1'b1 || acertou !== win || errou !== !win)
      $display("FAIL %s_flags pronto=%b acertou=%b errou=%b exp_win=%b", name, pronto, acertou, errou, win);
    else passes++;
    checks++; if (db_estado !== seg(win ? 10 : 14) || db_contagem !== seg(last))
      $display("FAIL %s_displays estado=%b cont=%b exp_estado=%b exp_cont=%b",
               name, db_estado, db_contagem, seg(win ? 10 : 14), seg(last));
    else passes++;
    checks++; if (db_chaves !== seg(int'(e[last])) || db_memoria !== seg(rom_m[last]) || db_igual !== win)
      $display("FAIL %s_entry chaves=%b mem=%b igual=%b", name, db_chaves, db_memoria, db_igual);
    else passes++;
    $display("game %s: first_bad=%0d win=%0b", name, k, win);
  endtask

  task automatic test_full_win();
    logic [3:0] e [16];
    for (int i = 0; i < 16; i++) e[i] = 4'(rom_m[i]);
    drive_game(e);
    check_end(e, "win");
  endtask

  task automatic test_fixed_error();
    logic [3:0] e [16];
    for (int i = 0; i < 16; i++) e[i] = 4'(rom_m[i]);
    e[4] = 4'h2;
    drive_game(e);
    check_end(e, "err4");
  endtask

  task automatic test_restart();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    checks++; if (db_estado !== seg(1) || errou !== 1'b0 || pronto !== 1'b0)
      $display("FAIL restart_prep estado=%b errou=%b pronto=%b", db_estado, errou, pronto);
    else passes++;
    tick();
    checks++; if (db_contagem !== seg(0) || db_chaves !== seg(0) || db_estado !== seg(4))
      $display("FAIL restart_clear cont=%b chaves=%b estado=%b", db_contagem, db_chaves, db_estado);
    else passes++;
    $display("restart: done");
    apply_reset();
  endtask

  task automatic test_reset_midgame();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      chaves = 4'(rom_m[i]);
      tick(); tick(); tick();
    end
    chaves = 4'h4;
    tick();
    #2 reset = 1'b0;
    #1;
    checks++; if (db_estado !== seg(0) || db_contagem !== seg(0) || db_chaves !== seg(0) ||
                  pronto !== 1'b0 || acertou !== 1'b0 || errou !== 1'b0)
      $display("FAIL midgame_reset estado=%b cont=%b chaves=%b pronto=%b", db_estado, db_contagem, db_chaves, pronto);
    else passes++;
    #1 reset = 1'b1;
    tick(); tick(); tick();
    checks++; if (db_estado !== seg(0)) $display("FAIL midgame_needs_start estado=%b exp=%b", db_estado, seg(0));
    else passes++;
    $display("reset_midgame: done");
  endtask

  task automatic test_random_games();
    logic [3:0] e [16];
    int k;
    for (int g = 0; g < 8; g++) begin
      for (int i = 0; i < 16; i++) e[i] = 4'(rom_m[i]);
      if ($urandom_range(0, 3) != 0) begin
        k = $urandom_range(0, 15);
        do e[k] = 4'($urandom_range(0, 15)); while (int'(e[k]) == rom_m[k]);
      end
      drive_game(e);
      check_end(e, $sformatf("rand%0d", g));
    end
    apply_reset();
  endtask

  task automatic test_chaves_sweep();
    for (int v = 0; v < 16; v++) begin
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      tick();
      chaves = 4'(v);
      tick();
      checks++; if (db_chaves !== seg(v) || db_igual !== (v == 1))
        $display("FAIL sweep_%0d chaves=%b exp=%b igual=%b", v, db_chaves, seg(v), db_igual);
      else passes++;
      $display("sweep: value %0d", v);
      apply_reset();
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_full_win();
    test_fixed_error();
    test_restart();
    test_reset_midgame();
    test_random_games();
    test_chaves_sweep();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/circuito_exp4_desafio_core.md
CIRCUITO_EXP4_DESAFIO_CORE -- requirements
Module: circuito_exp4_desafio_core

Interface
REQ-001 Ports SHALL be as follows; clock and reset first:
- clock  in  1  single system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- iniciar  in  1  start pulse; sampled on clock.
- chaves  in  4  player entry (one-hot in normal use).
- pronto  out  1  game finished.
- acertou  out  1  all 16 entries correct.
- errou  out  1  an entry mismatched.
- db_igual  out  1  registered entry equals current memory word.
- db_iniciar  out  1  mirror of iniciar.
- db_contagem  out  7  7-segment code of address counter.
- db_memoria  out  7  7-segment code of current memory word.
- db_chaves  out  7  7-segment code of registered entry.
- db_estado  out  7  7-segment code of FSM state.
REQ-002 Parameters SHALL be: none. Depth is fixed at 16 words, width 4 bits.

Function
REQ-003 Internal ROM, 16x4, addressed by the 4-bit counter, SHALL hold, addresses 0..15: 1,2,4,8,4,2,1,1,2,2,4,4,8,8,1,4 (hex).
REQ-004 The 4-bit entry register SHALL load chaves only in state REGISTRA, clear in PREPARACAO, and hold otherwise.
REQ-005 db_igual SHALL be combinational: (register == ROM[counter]).
REQ-006 The counter SHALL clear in PREPARACAO, increment by 1 only in PROXIMO, and hold otherwise.
REQ-007 The FSM state codes SHALL be: INICIAL=0, PREPARACAO=1, REGISTRA=4, COMPARACAO=5, PROXIMO=6, FIM_ACERTOU=A, FIM_ERROU=E (hex).
REQ-008 INICIAL SHALL go to PREPARACAO if iniciar=1, else stay.
REQ-009 PREPARACAO SHALL go to REGISTRA unconditionally.
REQ-010 REGISTRA SHALL go to COMPARACAO unconditionally.
REQ-011 COMPARACAO transitions SHALL be:
- db_igual=0 -> FIM_ERROU.
- db_igual=1 and counter=15 -> FIM_ACERTOU.
- db_igual=1 and counter<15 -> PROXIMO.
REQ-012 PROXIMO SHALL go to REGISTRA; each entry therefore takes exactly 3 clocks.
REQ-013 FIM_ACERTOU and FIM_ERROU SHALL stay until iniciar=1, then go to PREPARACAO.
REQ-014 The counter SHALL never wrap, because address 15 is terminal.
REQ-015 Outputs SHALL be Moore-style, decoded from state:
- pronto=1 in both FIM states.
- acertou=1 only in FIM_ACERTOU.
- errou=1 only in FIM_ERROU.
REQ-016 The 7-segment encoding SHALL be active-low, segment order gfedcba:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
- 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-017 db_estado SHALL display the 4-bit state code.
REQ-018 iniciar outside INICIAL and FIM states SHALL be ignored.

Reset
REQ-019 reset=0 SHALL, asynchronously:
- force state to INICIAL;
- clear the counter and the entry register;
- drive pronto=acertou=errou=0;
- set db_contagem, db_chaves and db_estado to the code for 0;
- set db_memoria to the code for 1.
REQ-020 Reset asserted mid-game SHALL abort the game; a new iniciar pulse SHALL then be required.

Structure
REQ-021 A shared package SHALL hold the state encoding constants and the ROM contents.
REQ-022 The block SHALL contain:
- one 7-segment decoder sub-module, hexa7seg, instantiated four times;
- the ROM, counter, register and FSM inline.

Verification
REQ-023 Reset then iniciar pulse -> state passes 0->1->4; counter=0; pronto=0.
REQ-024 Enter all 16 ROM values, each held 3 clocks in sequence -> FIM_ACERTOU; pronto=1, acertou=1, errou=0; db_estado shows A; db_contagem shows F.
REQ-025 Enter 1,2,4,8 correctly, then 2 at address 4 (expected 4) -> FIM_ERROU; pronto=1, errou=1, acertou=0; db_contagem shows 4; db_estado shows E.
REQ-026 Assert reset=0 during the 3rd entry -> state 0, counter 0, outputs low, immediately and without waiting for a clock edge.
REQ-027 From FIM_ERROU, pulse iniciar -> PREPARACAO; counter and register cleared; errou=0.
REQ-028 Sweep the register through 0..F -> db_chaves matches the REQ-016 table for each value.
